// File: rtl/clk_div_gen_if.sv
// Clock divider status/control bundle: run request in, divided clocks, strobes and lock status out.
interface clk_div_gen_if;
   logic en;
   logic sys_clk;
   logic sys_clk10;
   logic sys_clk_stb;
   logic sys_clk10_stb;
   logic locked;

   modport master (
      input  en,
      output sys_clk, sys_clk10, sys_clk_stb, sys_clk10_stb, locked
   );

   modport slave (
      output en,
      input  sys_clk, sys_clk10, sys_clk_stb, sys_clk10_stb, locked
   );
endinterface

// File: rtl/clk_div_gen.sv
// Two 50%-duty clock dividers with rising-edge strobes and a sticky lock flag.
// Define CLKGEN_GATE_EN to compile in per-divider run/stop gating controlled by en.
module clk_div_gen #(
   parameter int DIV_A       = 2,
   parameter int DIV_B       = 10,
   parameter int LOCK_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   clk_div_gen_if.master  bus
);

   for (genvar g = 0; g < 2; g++) begin : g_div
      localparam int DIV = (g == 0) ? DIV_A : DIV_B;
      localparam int CW  = $clog2(DIV);
      localparam logic [CW-1:0] LAST = CW'(DIV - 1);
      localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

      logic [CW-1:0] cnt;
      logic          q;
      logic          stb;
      logic          run;
      logic          wrap;
      logic          toggle;

      assign wrap   = (cnt == LAST);
      assign toggle = wrap || (cnt == HALF);

`ifdef CLKGEN_GATE_EN
      typedef enum logic [1:0] {RUN, STOP_PEND, STOPPED} gate_t;
      gate_t state, state_nx;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) state <= RUN;
         else        state <= state_nx;
      end

      // Stopping only on the wrap edge guarantees the output is already falling to 0.
      always_comb begin
         state_nx = state;
         run      = 1'b1;
         unique case (state)
            RUN: begin
               if (!bus.en) state_nx = STOP_PEND;
            end
            STOP_PEND: begin
               if (bus.en)    state_nx = RUN;
               else if (wrap) state_nx = STOPPED;
            end
            STOPPED: begin
               run = 1'b0;
               if (bus.en) state_nx = RUN;
            end
            default: state_nx = RUN;
         endcase
      end
`else
      logic unused_en;
      assign unused_en = bus.en;
      assign run       = 1'b1;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
            stb <= 1'b0;
         end else if (run) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (toggle) q <= ~q;
            stb <= toggle & ~q;
         end else begin
            cnt <= '0;
            q   <= 1'b0;
            stb <= 1'b0;
         end
      end
   end

   assign bus.sys_clk       = g_div[0].q;
   assign bus.sys_clk_stb   = g_div[0].stb;
   assign bus.sys_clk10     = g_div[1].q;
   assign bus.sys_clk10_stb = g_div[1].stb;

   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

   logic [LW-1:0] lock_cnt;
   logic [LW-1:0] lock_nx;
   logic          locked_q;

   always_comb begin
      lock_nx = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
   end

   // Compare the post-increment count so locked rises on edge LOCK_CYCLES itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
         locked_q <= 1'b0;
      end else begin
         lock_cnt <= lock_nx;
         locked_q <= locked_q | (lock_nx == LOCK_MAX);
      end
   end

   assign bus.locked = locked_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: edge-count reference model plus directed literal checks.
module tb_clk_div_gen;
   localparam int DIV_A = 2;
   localparam int DIV_B = 10;
   localparam int LOCK  = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   clk_div_gen_if bus ();

   clk_div_gen #(
      .DIV_A       (DIV_A),
      .DIV_B       (DIV_B),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   function automatic int div_of(input int i);
      return (i == 0) ? DIV_A : DIV_B;
   endfunction

   // Reference: n[i] counts running edges since (re)start; output level and strobe
   // follow from where n sits relative to the first rise at DIV/2.
   int n [2];
   bit pend [2];
   bit stp [2];
   bit m_out [2];
   bit m_stb [2];
   int lk;
   bit m_locked;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            n[i] = 0; pend[i] = 0; stp[i] = 0; m_out[i] = 0; m_stb[i] = 0;
         end
         lk = 0;
         m_locked = 0;
      end else begin
         if (lk < LOCK) lk++;
         m_locked = (lk >= LOCK);
         for (int i = 0; i < 2; i++) begin
            m_stb[i] = 0;
            if (stp[i]) begin
               if (bus.en) stp[i] = 0;
               m_out[i] = 0;
            end else begin
               n[i]++;
               m_out[i] = (n[i] >= div_of(i) / 2) && (((n[i] - div_of(i) / 2) % div_of(i)) < div_of(i) / 2);
               m_stb[i] = (n[i] >= div_of(i) / 2) && (((n[i] - div_of(i) / 2) % div_of(i)) == 0);
`ifdef CLKGEN_GATE_EN
               if (bus.en) pend[i] = 0;
               else if (!pend[i]) pend[i] = 1;
               else if (n[i] % div_of(i) == 0) begin
                  stp[i] = 1; pend[i] = 0; n[i] = 0;
               end
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      check("m_sys_clk",       bus.sys_clk,       m_out[0]);
      check("m_sys_clk10",     bus.sys_clk10,     m_out[1]);
      check("m_sys_clk_stb",   bus.sys_clk_stb,   m_stb[0]);
      check("m_sys_clk10_stb", bus.sys_clk10_stb, m_stb[1]);
      check("m_locked",        bus.locked,        m_locked);
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_sys_clk",   bus.sys_clk,   1'b0);
      check("rst_sys_clk10", bus.sys_clk10, 1'b0);
      check("rst_stb",       bus.sys_clk_stb | bus.sys_clk10_stb, 1'b0);
      check("rst_locked",    bus.locked,    1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Free-running waveform pinned with literal expectations for edges 1..30.
   task automatic free_run_literals();
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         check("lit_sys_clk",     bus.sys_clk,     logic'(e % 2));
         check("lit_sys_clk_stb", bus.sys_clk_stb, logic'(e % 2));
         check("lit_sys_clk10_stb", bus.sys_clk10_stb, logic'(e == 5 || e == 15 || e == 25));
         if (e <= 14) check("lit_sys_clk10", bus.sys_clk10, logic'(e >= 5 && e <= 9));
         check("lit_locked", bus.locked, logic'(e >= 16));
      end
   endtask

   initial begin
      bus.en = 1'b1;

      do_reset();
      free_run_literals();

`ifdef CLKGEN_GATE_EN
      do_reset();
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         if (e == 5)  bus.en = 1'b0;
         if (e == 19) bus.en = 1'b1;
         check("gate_sys_clk10", bus.sys_clk10, logic'((e >= 5 && e <= 9) || (e >= 25 && e <= 29)));
         check("gate_sys_clk10_stb", bus.sys_clk10_stb, logic'(e == 5 || e == 25));
         if (e >= 11 && e <= 20) check("gate_cnt_zero", logic'(dut.g_div[1].cnt == '0), 1'b1);
      end
`else
      bus.en = 1'b0;
      do_reset();
      free_run_literals();
      bus.en = 1'b1;
`endif

      // Asynchronous reset in the middle of a sys_clk10 high phase.
      do_reset();
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_sys_clk",   bus.sys_clk,   1'b0);
      check("async_sys_clk10", bus.sys_clk10, 1'b0);
      check("async_stb",       bus.sys_clk_stb | bus.sys_clk10_stb, 1'b0);
      check("async_locked",    bus.locked,    1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk);
         #1;
         check("rel_sys_clk10",     bus.sys_clk10,     logic'(e == 5 || e == 6));
         check("rel_sys_clk10_stb", bus.sys_clk10_stb, logic'(e == 5));
      end

      // Randomised run-request activity with occasional asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
         if ($urandom_range(0, 599) == 0) begin
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
